// File: rtl/adc_pkg.sv
// adc_pkg: shared state encoding and channel-index width helper for the scan receiver.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } adc_state_e;

   // Channel index width; never narrower than one bit.
   function automatic int calc_ch_w(input int num_channels);
      return (num_channels <= 2) ? 1 : $clog2(num_channels);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCK half-period divider with rise/fall strobes, enable and clear.
module spi_clk_gen #(
   parameter int DIVISOR = 50
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   input  logic i_sck_en,
   output logic o_sck,
   output logic o_tick,
   output logic o_rise,
   output logic o_fall
);
   localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sck_q, sck_d;

   // Strobes fire in the cycle the counter wraps; SCK itself changes on the following edge.
   assign o_tick = i_en && !i_clr && (cnt_q == CNT_W'(DIVISOR - 1));
   assign o_rise = o_tick && i_sck_en && !sck_q;
   assign o_fall = o_tick && i_sck_en && sck_q;
   assign o_sck  = sck_q;

   // Next counter and SCK level; clear wins over enable and parks SCK low.
   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (i_clr) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (i_en) begin
         cnt_d = o_tick ? '0 : cnt_q + CNT_W'(1);
         if (o_rise || o_fall) begin
            sck_d = !sck_q;
         end
      end
   end

   // Counter and SCK registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

endmodule

// File: rtl/adc_scan_receiver.sv
// adc_scan_receiver: masked multi-channel scan controller for a pipelined SAR ADC.
// Frame k shifts out the command for one channel and shifts in the conversion
// commanded in frame k-1, so every scan opens with a dummy frame and closes by
// re-commanding the first enabled channel.
module adc_scan_receiver
   import adc_pkg::*;
#(
   parameter int SPI_CLK_DIVISOR = 50,
   parameter int DATA_BITS       = 12,
   parameter int CMD_BITS        = 8,
   parameter int NUM_CHANNELS    = 4,
   parameter int CONV_CYCLES     = 200,
   localparam int CH_W           = calc_ch_w(NUM_CHANNELS)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic                     i_continuous,
   input  logic [NUM_CHANNELS-1:0]  i_chan_mask,
   input  logic [CMD_BITS-CH_W-1:0] i_cmd_cfg,
   output logic                     o_rx_dv,
   output logic [DATA_BITS-1:0]     o_rx_data,
   output logic [CH_W-1:0]          o_rx_chan,
   output logic                     o_busy,
   output logic                     o_scan_done,
   input  logic                     i_serial_rx,
   output logic                     o_convst,
   output logic                     o_sck,
   output logic                     o_serial_tx,
   output adc_state_e               o_state
);
   localparam int CFG_W  = CMD_BITS - CH_W;
   localparam int CONV_W = $clog2(CONV_CYCLES + 1);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   adc_state_e               state_q, state_d;
   logic [CONV_W-1:0]        conv_cnt_q, conv_cnt_d;
   logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [NUM_CHANNELS-1:0]  mask_q, mask_d;
   logic [CFG_W-1:0]         cfg_q, cfg_d;
   logic [CH_W-1:0]          cur_ch_q, cur_ch_d;
   logic [CH_W-1:0]          prev_ch_q, prev_ch_d;
   logic                     dummy_q, dummy_d;
   logic                     last_q, last_d;
   logic [CMD_BITS-1:0]      tx_sr_q, tx_sr_d;
   logic [DATA_BITS-1:0]     rx_sr_q, rx_sr_d;
   logic                     rx_dv_q, rx_dv_d;
   logic [DATA_BITS-1:0]     rx_data_q, rx_data_d;
   logic [CH_W-1:0]          rx_chan_q, rx_chan_d;
   logic                     scan_done_q, scan_done_d;
   logic                     convst_q, convst_d;
   logic                     busy_q, busy_d;

   logic                     start_scan;
   logic                     next_found;
   logic [CH_W-1:0]          next_ch, first_q_ch, first_in_ch;
   logic                     sck_tick, sck_rise, sck_fall;

   spi_clk_gen #(
      .DIVISOR (SPI_CLK_DIVISOR)
   ) u_spi_clk_gen (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     ((state_q == SHIFT) || (state_q == GAP)),
      .i_clr    ((state_q == IDLE) || (state_q == CONV)),
      .i_sck_en (state_q == SHIFT),
      .o_sck    (o_sck),
      .o_tick   (sck_tick),
      .o_rise   (sck_rise),
      .o_fall   (sck_fall)
   );

   // Channel search: lowest enabled channel above the current one, and lowest enabled overall.
   always_comb begin
      next_found  = 1'b0;
      next_ch     = '0;
      first_q_ch  = '0;
      first_in_ch = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (mask_q[i] && (CH_W'(i) > cur_ch_q)) begin
            next_found = 1'b1;
            next_ch    = CH_W'(i);
         end
         if (mask_q[i]) begin
            first_q_ch = CH_W'(i);
         end
         if (i_chan_mask[i]) begin
            first_in_ch = CH_W'(i);
         end
      end
   end

   // Frame sequencing: conversion, serial exchange, gap, then publish and pick the next frame.
   always_comb begin
      state_d     = state_q;
      conv_cnt_d  = conv_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      mask_d      = mask_q;
      cfg_d       = cfg_q;
      cur_ch_d    = cur_ch_q;
      prev_ch_d   = prev_ch_q;
      dummy_d     = dummy_q;
      last_d      = last_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      rx_dv_d     = 1'b0;
      rx_data_d   = rx_data_q;
      rx_chan_d   = rx_chan_q;
      scan_done_d = 1'b0;
      start_scan  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start && (|i_chan_mask)) begin
               start_scan = 1'b1;
            end
         end
         CONV: begin
            if (conv_cnt_q == CONV_W'(CONV_CYCLES - 1)) begin
               state_d    = SHIFT;
               conv_cnt_d = '0;
               bit_cnt_d  = '0;
               tx_sr_d    = {cfg_q, cur_ch_q};
            end else begin
               conv_cnt_d = conv_cnt_q + CONV_W'(1);
            end
         end
         SHIFT: begin
            if (sck_rise) begin
               rx_sr_d = {rx_sr_q[DATA_BITS-2:0], i_serial_rx};
            end
            if (sck_fall) begin
               tx_sr_d = tx_sr_q << 1;
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  state_d = GAP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         GAP: begin
            if (sck_tick) begin
               if (!dummy_q) begin
                  rx_dv_d   = 1'b1;
                  rx_data_d = rx_sr_q;
                  rx_chan_d = prev_ch_q;
               end
               if (!last_q) begin
                  state_d   = CONV;
                  prev_ch_d = cur_ch_q;
                  dummy_d   = 1'b0;
                  if (next_found) begin
                     cur_ch_d = next_ch;
                  end else begin
                     // Wrap back to the first channel; that frame only collects the last sample.
                     cur_ch_d = first_q_ch;
                     last_d   = 1'b1;
                  end
               end else begin
                  scan_done_d = 1'b1;
                  if (i_continuous && (|i_chan_mask)) begin
                     start_scan = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (start_scan) begin
         state_d    = CONV;
         mask_d     = i_chan_mask;
         cfg_d      = i_cmd_cfg;
         cur_ch_d   = first_in_ch;
         dummy_d    = 1'b1;
         last_d     = 1'b0;
         conv_cnt_d = '0;
      end
      convst_d = (state_d == CONV);
      busy_d   = (state_d != IDLE);
   end

   // All state and output registers, synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         conv_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         mask_q      <= '0;
         cfg_q       <= '0;
         cur_ch_q    <= '0;
         prev_ch_q   <= '0;
         dummy_q     <= 1'b0;
         last_q      <= 1'b0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         rx_dv_q     <= 1'b0;
         rx_data_q   <= '0;
         rx_chan_q   <= '0;
         scan_done_q <= 1'b0;
         convst_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         conv_cnt_q  <= conv_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         mask_q      <= mask_d;
         cfg_q       <= cfg_d;
         cur_ch_q    <= cur_ch_d;
         prev_ch_q   <= prev_ch_d;
         dummy_q     <= dummy_d;
         last_q      <= last_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         rx_dv_q     <= rx_dv_d;
         rx_data_q   <= rx_data_d;
         rx_chan_q   <= rx_chan_d;
         scan_done_q <= scan_done_d;
         convst_q    <= convst_d;
         busy_q      <= busy_d;
      end
   end

   assign o_rx_dv     = rx_dv_q;
   assign o_rx_data   = rx_data_q;
   assign o_rx_chan   = rx_chan_q;
   assign o_busy      = busy_q;
   assign o_scan_done = scan_done_q;
   assign o_convst    = convst_q;
   assign o_serial_tx = tx_sr_q[CMD_BITS-1];
   assign o_state     = state_q;

endmodule

// File: tb/tb_adc_scan_receiver.sv
// tb_adc_scan_receiver: directed scans against a bench-side ADC and a scan-level model.
module tb_adc_scan_receiver;
   import adc_pkg::*;

   localparam int DIV   = 2;
   localparam int CONVC = 4;
   localparam int DB    = 12;
   localparam int CB    = 8;
   localparam int NCH   = 4;
   localparam int FRAME = CONVC + 2 * DB * DIV + DIV;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           start = 1'b0;
   logic           cont = 1'b0;
   logic [NCH-1:0] mask = '0;
   logic [5:0]     cfg = '0;
   logic           serial_rx = 1'b0;
   logic           o_rx_dv, o_busy, o_scan_done, o_convst, o_sck, o_serial_tx;
   logic [DB-1:0]  o_rx_data;
   logic [1:0]     o_rx_chan;
   adc_state_e     dbg_state;

   adc_scan_receiver #(
      .SPI_CLK_DIVISOR (DIV),
      .DATA_BITS       (DB),
      .CMD_BITS        (CB),
      .NUM_CHANNELS    (NCH),
      .CONV_CYCLES     (CONVC)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_continuous (cont),
      .i_chan_mask  (mask),
      .i_cmd_cfg    (cfg),
      .o_rx_dv      (o_rx_dv),
      .o_rx_data    (o_rx_data),
      .o_rx_chan    (o_rx_chan),
      .o_busy       (o_busy),
      .o_scan_done  (o_scan_done),
      .i_serial_rx  (serial_rx),
      .o_convst     (o_convst),
      .o_sck        (o_sck),
      .o_serial_tx  (o_serial_tx),
      .o_state      (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [CB-1:0] exp_cmd_q[$];   // command words expected, one per frame
   logic [14:0]   exp_smp_q[$];   // {last_of_scan, chan, data}
   logic [13:0]   obs_q[$];       // observed {chan, data}
   logic [CB-1:0] cmd_log[$];     // commands the ADC received
   int checks = 0;
   int failures = 0;
   int rx_cnt = 0;
   int done_cnt = 0;
   int conv_rise_cnt = 0;
   logic [1:0] done_chan = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scan-level model: commands for each enabled channel in ascending order plus the
   // first one again; one sample per enabled channel, value 0x100 + channel.
   task automatic push_scan(input logic [NCH-1:0] m, input logic [5:0] c);
      logic [1:0] first_ch, last_ch, ch;
      first_ch = '0;
      last_ch = '0;
      for (int i = NCH - 1; i >= 0; i--) if (m[i]) first_ch = 2'(i);
      for (int i = 0; i < NCH; i++) if (m[i]) last_ch = 2'(i);
      for (int i = 0; i < NCH; i++) begin
         if (m[i]) begin
            ch = 2'(i);
            exp_cmd_q.push_back({c, ch});
            exp_smp_q.push_back({(ch == last_ch), ch, 12'h100 + 12'(i)});
         end
      end
      exp_cmd_q.push_back({c, first_ch});
   endtask

   // ---------------- bench-side ADC ----------------
   logic [DB-1:0] adc_word = '0;
   logic [CB-1:0] adc_cmd = '0;
   logic [CB-1:0] adc_cmd_sr = '0;
   int adc_rises = 0;

   always @(posedge o_convst) begin
      adc_word = 12'h100 + {10'd0, adc_cmd[1:0]};
      serial_rx = adc_word[DB-1];
      adc_rises = 0;
   end

   always @(posedge o_sck) begin
      if (adc_rises < CB) adc_cmd_sr = {adc_cmd_sr[CB-2:0], o_serial_tx};
      adc_rises++;
      if (adc_rises == CB) begin
         adc_cmd = adc_cmd_sr;
         cmd_log.push_back(adc_cmd);
      end
   end

   always @(negedge o_sck) begin
      adc_word = adc_word << 1;
      serial_rx = adc_word[DB-1];
   end

   // ---------------- compare process ----------------
   int cyc = 0;
   int rises = 0;
   int last_conv_cyc = 0;
   int last_rise_cyc = 0;
   logic sck_prev = 1'b0, conv_prev = 1'b0, tx_prev = 1'b0;
   logic frame_open = 1'b0, conv_valid = 1'b0;
   logic [CB-1:0] cur_cmd = '0;
   logic [14:0] e;
   logic exp_bit;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         sck_prev = 1'b0;
         conv_prev = 1'b0;
         tx_prev = 1'b0;
         frame_open = 1'b0;
         conv_valid = 1'b0;
         rises = 0;
      end else begin
         if (o_convst && !conv_prev) begin
            conv_rise_cnt++;
            if (frame_open) check("sck_rises_per_frame", rises, DB);
            if (conv_valid) check("frame_length", cyc - last_conv_cyc, FRAME);
            if (exp_cmd_q.size() == 0) check("unexpected_frame", 1, 0);
            else cur_cmd = exp_cmd_q.pop_front();
            rises = 0;
            frame_open = 1'b1;
            conv_valid = 1'b1;
            last_conv_cyc = cyc;
         end
         if (!o_convst && conv_prev) check("convst_width", cyc - last_conv_cyc, CONVC);
         if (o_sck && !sck_prev) begin
            rises++;
            if (rises > 1) check("sck_period", cyc - last_rise_cyc, 2 * DIV);
            check("sdi_stable", o_serial_tx, tx_prev);
            exp_bit = (rises <= CB) ? cur_cmd[CB-rises] : 1'b0;
            check("sdi_bit", o_serial_tx, exp_bit);
            last_rise_cyc = cyc;
         end
         if (o_rx_dv) begin
            rx_cnt++;
            obs_q.push_back({o_rx_chan, o_rx_data});
            if (exp_smp_q.size() == 0) begin
               check("unexpected_rx_dv", 1, 0);
            end else begin
               e = exp_smp_q.pop_front();
               check("rx_chan", o_rx_chan, e[13:12]);
               check("rx_data", o_rx_data, e[11:0]);
               check("scan_done_with_last", o_scan_done, e[14]);
               if (!e[14] || exp_cmd_q.size() != 0) begin
                  check("no_gap_convst", o_convst, 1);
               end else begin
                  check("end_busy_low", o_busy, 0);
                  check("last_frame_rises", rises, DB);
                  frame_open = 1'b0;
               end
            end
         end else if (o_scan_done) begin
            check("scan_done_without_rx_dv", 1, 0);
         end
         if (o_scan_done) begin
            done_cnt++;
            done_chan = o_rx_chan;
         end
         if (!o_busy) conv_valid = 1'b0;
         sck_prev = o_sck;
         conv_prev = o_convst;
         tx_prev = o_serial_tx;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      exp_cmd_q.delete();
      exp_smp_q.delete();
      tick();
      check("reset_outputs", {o_sck, o_convst, o_serial_tx, o_busy, o_rx_dv, o_scan_done,
                              o_rx_chan, o_rx_data}, 0);
      check("reset_state", 32'(dbg_state), 32'(IDLE));
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic start_scan(input logic [NCH-1:0] m, input logic [5:0] c);
      mask = m;
      cfg = c;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (m != 0) begin
         check("start_busy", o_busy, 1);
         check("start_convst", o_convst, 1);
      end else begin
         check("zero_mask_busy", o_busy, 0);
      end
   endtask

   task automatic wait_done(input int target, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < 3000) begin
         tick();
         n++;
      end
      check(name, (done_cnt >= target), 1);
      tick();
   endtask

   // ---------------- directed sequence ----------------
   int base_rx, base_done, base_conv, n;
   logic act;

   initial begin
      apply_reset();

      // Mixed mask 1011, cfg 0x2A.
      cmd_log.delete();
      obs_q.delete();
      push_scan(4'b1011, 6'h2A);
      base_done = done_cnt;
      start_scan(4'b1011, 6'h2A);
      wait_done(base_done + 1, "t1_timeout");
      check("t1_sample_count", obs_q.size(), 3);
      check("t1_cmd_count", cmd_log.size(), 4);
      if (obs_q.size() == 3) begin
         check("t1_s0", obs_q[0], 14'h0100);
         check("t1_s1", obs_q[1], 14'h1101);
         check("t1_s2", obs_q[2], 14'h3103);
      end
      if (cmd_log.size() == 4) begin
         check("t1_c0", cmd_log[0], 8'hA8);
         check("t1_c1", cmd_log[1], 8'hA9);
         check("t1_c2", cmd_log[2], 8'hAB);
         check("t1_c3", cmd_log[3], 8'hA8);
      end
      check("t1_done_chan", done_chan, 2'd3);
      check("t1_idle_busy", o_busy, 0);

      // Single channel 2.
      cmd_log.delete();
      obs_q.delete();
      push_scan(4'b0100, 6'h15);
      base_done = done_cnt;
      start_scan(4'b0100, 6'h15);
      wait_done(base_done + 1, "t2_timeout");
      check("t2_sample_count", obs_q.size(), 1);
      if (obs_q.size() == 1) check("t2_s0", obs_q[0], 14'h2102);
      check("t2_cmd_count", cmd_log.size(), 2);
      if (cmd_log.size() == 2) begin
         check("t2_c0", cmd_log[0], 8'h56);
         check("t2_c1", cmd_log[1], 8'h56);
      end

      // Continuous, three scans of mask 0011.
      base_rx = rx_cnt;
      base_done = done_cnt;
      push_scan(4'b0011, 6'h05);
      push_scan(4'b0011, 6'h05);
      push_scan(4'b0011, 6'h05);
      cont = 1'b1;
      start_scan(4'b0011, 6'h05);
      wait_done(base_done + 2, "t3_timeout_a");
      cont = 1'b0;
      wait_done(base_done + 3, "t3_timeout_b");
      check("t3_samples", rx_cnt - base_rx, 6);
      check("t3_done_pulses", done_cnt - base_done, 3);

      // Zero mask start is ignored.
      act = 1'b0;
      start_scan(4'b0000, 6'h3F);
      for (int i = 0; i < 20; i++) begin
         if (o_busy || o_convst || o_sck || o_serial_tx) act = 1'b1;
         tick();
      end
      check("zero_mask_idle", act, 0);

      // Start and input changes during a scan are ignored.
      base_rx = rx_cnt;
      base_done = done_cnt;
      push_scan(4'b1011, 6'h2A);
      start_scan(4'b1011, 6'h2A);
      repeat (60) tick();
      mask = 4'b1111;
      cfg = 6'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(base_done + 1, "t5_timeout");
      check("t5_samples", rx_cnt - base_rx, 3);

      // Reset during the SHIFT of frame 2.
      base_rx = rx_cnt;
      base_conv = conv_rise_cnt;
      push_scan(4'b1111, 6'h3C);
      start_scan(4'b1111, 6'h3C);
      n = 0;
      while (conv_rise_cnt < base_conv + 3 && n < 1000) begin
         tick();
         n++;
      end
      check("t6_frame2_reached", (conv_rise_cnt >= base_conv + 3), 1);
      repeat (CONVC + 10) tick();
      check("t6_rx_before_reset", rx_cnt - base_rx, 1);
      apply_reset();
      repeat (100) tick();
      check("t6_no_rx_after_reset", rx_cnt - base_rx, 1);
      check("t6_idle_after_reset", o_busy, 0);

      // Fresh scan after reset.
      obs_q.delete();
      base_done = done_cnt;
      push_scan(4'b0110, 6'h01);
      start_scan(4'b0110, 6'h01);
      wait_done(base_done + 1, "t7_timeout");
      check("t7_sample_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         check("t7_s0", obs_q[0], 14'h1101);
         check("t7_s1", obs_q[1], 14'h2102);
      end

      check("exp_cmd_left", exp_cmd_q.size(), 0);
      check("exp_smp_left", exp_smp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
